// File: rtl/comparator_pkg.sv
// Shared types for the sequential branch comparator: funct3 mode encoding,
// FSM state encoding and the legal-mode helper.
package comparator_pkg;

  typedef enum logic [2:0] {
    MODE_EQ  = 3'b000,
    MODE_NE  = 3'b001,
    MODE_LT  = 3'b100,
    MODE_GE  = 3'b101,
    MODE_LTU = 3'b110,
    MODE_GEU = 3'b111
  } cmp_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_t;

  // funct3 values 010 and 011 are not branch conditions
  function automatic logic is_legal_mode(input logic [2:0] m);
    return !((m == 3'b010) || (m == 3'b011));
  endfunction

endpackage

// File: rtl/comparator_seq_if.sv
// Request/result bundle for comparator_seq: valid/ready request side plus
// a one-cycle result strobe.
interface comparator_seq_if #(parameter int N = 32);
  logic         i_valid;
  logic         ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   mode;
  logic         o_valid;
  logic         out;
  logic         err;

  modport master (output i_valid, a, b, mode, input ready, o_valid, out, err);
  modport slave  (input i_valid, a, b, mode, output ready, o_valid, out, err);
endinterface

// File: rtl/comparator_slice.sv
// Combinational W-bit slice comparator; lt is signed when is_signed is set.
module comparator_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] sa,
  input  logic [W-1:0] sb,
  input  logic         is_signed,
  output logic         eq,
  output logic         lt
);

  always_comb begin
    eq = (sa == sb);
    if (is_signed) lt = ($signed(sa) < $signed(sb));
    else           lt = (sa < sb);
  end

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle RISC-V branch comparator: scans W-bit slices MSB-first and
// stops at the first differing slice.
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  comparator_seq_if.slave   bus
);

  localparam int S  = N / W;
  localparam int KW = (S > 1) ? $clog2(S) : 1;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SCAN = ST_SCAN;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]    mode_q, mode_d;
  logic          out_q, out_d, err_q, err_d;

  logic [W-1:0]  slice_a, slice_b;
  logic          slice_signed, slice_eq, slice_lt;
  logic          accept;

  assign bus.ready   = (state_q == IDLE) || (state_q == DONE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.out     = out_q;
  assign bus.err     = err_q;
  assign accept      = bus.i_valid && bus.ready;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < S; i++) begin
      if (k_q == KW'(i)) begin
        slice_a = a_q[i*W +: W];
        slice_b = b_q[i*W +: W];
      end
    end
    // Only the top slice carries the sign, and only for the signed modes
    slice_signed = (k_q == KW'(S-1)) &&
                   ((mode_q == MODE_LT) || (mode_q == MODE_GE));
  end

  comparator_slice #(.W(W)) u_slice (
    .sa        (slice_a),
    .sb        (slice_b),
    .is_signed (slice_signed),
    .eq        (slice_eq),
    .lt        (slice_lt)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    out_d   = out_q;
    err_d   = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          k_d     = KW'(S-1);
          state_d = SCAN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!slice_eq || (k_q == '0)) begin
          // slice_lt is already 0 when the final slices are equal
          case (mode_q)
            MODE_EQ:           out_d = slice_eq;
            MODE_NE:           out_d = !slice_eq;
            MODE_LT, MODE_LTU: out_d = slice_lt;
            MODE_GE, MODE_GEU: out_d = !slice_lt;
            default:           out_d = 1'b0;
          endcase
          err_d   = !is_legal_mode(mode_q);
          state_d = DONE;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= KW'(S-1);
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Self-checking bench for comparator_seq (N=32, W=8): directed cases plus
// randomized requests checked against an arithmetic reference model.
module tb_comparator_seq;

  localparam int N = 32;
  localparam int W = 8;
  localparam int S = N / W;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  comparator_seq_if #(.N(N)) bus ();

  comparator_seq #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_out(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic [2:0] m);
    case (m)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) <  $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a <  b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] m);
    return (m == 3'b010) || (m == 3'b011);
  endfunction

  // cycles from accept to strobe: slices examined (down to the first
  // difference, or all of them) plus one
  function automatic int ref_lat(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] diff;
    diff = a ^ b;
    for (int i = S - 1; i >= 0; i--)
      if ((diff >> (i * W)) != 0) return (S - i) + 1;
    return S + 1;
  endfunction

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!bus.ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
  endtask

  // waits for the strobe after an accept edge; lat counts from the accept edge
  task automatic wait_strobe(input string tag, input int exp_lat,
                             input logic exp_out, input logic exp_err);
    int lat;
    lat = 1;
    while (!bus.o_valid && lat < S + 6) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_ovalid"}, 32'(bus.o_valid), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_out"}, 32'(bus.out), 32'(exp_out));
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [2:0] m);
    logic eo;
    eo = ref_out(a, b, m);
    wait_ready(tag);
    bus.i_valid = 1'b1;
    bus.a       = a;
    bus.b       = b;
    bus.mode    = m;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.a       = $urandom;
    bus.b       = $urandom;
    bus.mode    = 3'($urandom);
    wait_strobe(tag, ref_lat(a, b), eo, ref_err(m));
    @(posedge clk); #1;
    check({tag, "_strobe_once"}, 32'(bus.o_valid), 32'd0);
    check({tag, "_held"}, 32'(bus.out), 32'(eo));
  endtask

  initial begin
    logic [N-1:0] ra, rb, mask;
    logic [2:0]   rm;
    int           keep;
    logic [2:0]   modes [8];

    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.mode    = 3'b000;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_ovalid", 32'(bus.o_valid), 32'd0);
    check("reset_out", 32'(bus.out), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", 32'(bus.ready), 32'd1);

    run_op("eq_all", 32'h12345678, 32'h12345678, 3'b000);
    run_op("lt_signed", 32'hFFFFFFFF, 32'h00000001, 3'b100);
    run_op("ltu_top", 32'hFFFFFFFF, 32'h00000001, 3'b110);
    run_op("ge_slice1", 32'h00000100, 32'h000000FF, 3'b101);
    run_op("geu_eq", 32'h80000000, 32'h80000000, 3'b111);
    run_op("lt_neg_eq", 32'h80000000, 32'h80000000, 3'b100);

    // back-to-back: second request accepted in the first's DONE cycle
    bus.i_valid = 1'b1;
    bus.a       = 32'd5;
    bus.b       = 32'd5;
    bus.mode    = 3'b001;
    @(posedge clk); #1;
    bus.b       = 32'd6;
    wait_strobe("b2b_first", S + 1, 1'b0, 1'b0);
    check("b2b_ready_in_done", 32'(bus.ready), 32'd1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check("b2b_no_bubble_ovalid", 32'(bus.o_valid), 32'd0);
    check("b2b_no_bubble_ready", 32'(bus.ready), 32'd0);
    wait_strobe("b2b_second", S + 1, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("b2b_idle_after", 32'(bus.o_valid), 32'd0);

    // set out=1, then abort an EQ request mid-scan
    run_op("pre_abort", 32'hCAFE0000, 32'hCAFE0000, 3'b000);
    wait_ready("abort");
    bus.i_valid = 1'b1;
    bus.a       = 32'hABCDEF01;
    bus.b       = 32'hABCDEF01;
    bus.mode    = 3'b000;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_out", 32'(bus.out), 32'd0);
    check("abort_ovalid", 32'(bus.o_valid), 32'd0);
    keep = 0;
    for (int i = 0; i < S + 3; i++) begin
      @(posedge clk); #1;
      if (bus.o_valid) keep++;
    end
    check("abort_no_strobe", 32'(keep), 32'd0);

    run_op("illegal_010", 32'h11112222, 32'h11113333, 3'b010);
    run_op("illegal_011", 32'h55555555, 32'h55555555, 3'b011);
    run_op("err_cleared", 32'h00000001, 32'h00000002, 3'b110);

    modes[0] = 3'b000; modes[1] = 3'b001; modes[2] = 3'b100; modes[3] = 3'b101;
    modes[4] = 3'b110; modes[5] = 3'b111; modes[6] = 3'b010; modes[7] = 3'b011;
    for (int t = 0; t < 60; t++) begin
      ra   = $urandom;
      keep = $urandom_range(0, S);
      if (keep == S) begin
        rb = ra;
      end else begin
        mask = 32'hFFFFFFFF >> (keep * W);
        rb   = (ra & ~mask) | ($urandom & mask);
      end
      rm = modes[$urandom_range(0, 7)];
      run_op($sformatf("rand%0d", t), ra, rb, rm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
